// File: rtl/if_id_pkg.sv
// IF/ID stage shared definitions.
//   - default instruction / PC widths
//   - NOP encoding shown to decode whenever the stage is empty
//   - occupancy encoding of the 2-entry skid buffer and a helper that forms it
package if_id_pkg;

    localparam int INST_W_DEF = 32;
    localparam int PC_W_DEF   = 32;

    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    function automatic logic [1:0] occ_count(input logic head_valid, input logic skid_valid);
        return {1'b0, head_valid} + {1'b0, skid_valid};
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer with valid/ready handshake and synchronous flush.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   in_valid/in_ready  upstream handshake; in_ready is a flop (= skid empty)
//   in_data            payload from upstream
//   flush              drop everything held and any same-cycle input
//   out_valid/out_ready downstream handshake
//   out_data           head entry, EMPTY_VAL whenever out_valid=0 (registered)
//   occupancy          number of entries held (0..2)
//
// occupancy | meaning
// ----------+------------------------------------------
// EMPTY     | nothing held, head shows EMPTY_VAL
// ONE       | head valid, skid free, in_ready=1
// FULL      | head and skid valid, in_ready=0
module pipe_skid_buf
    import if_id_pkg::*;
#(
    parameter int             W         = 64,
    parameter logic [W-1:0]   EMPTY_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occupancy
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] skid_q, skid_d;
    logic         head_valid_q, head_valid_d;
    logic         skid_valid_q, skid_valid_d;

    logic accept;
    logic pop;

    assign accept = in_valid && !skid_valid_q && !flush;
    assign pop    = head_valid_q && out_ready;

    always_comb begin
        head_d       = head_q;
        skid_d       = skid_q;
        head_valid_d = head_valid_q;
        skid_valid_d = skid_valid_q;

        if (flush) begin
            head_d       = EMPTY_VAL;
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            case (occ_count(head_valid_q, skid_valid_q))
                OCC_EMPTY: begin
                    if (accept) begin
                        head_d       = in_data;
                        head_valid_d = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (accept && pop) begin
                        head_d = in_data;
                    end else if (accept) begin
                        // Decode stalled: park the new word behind the head.
                        skid_d       = in_data;
                        skid_valid_d = 1'b1;
                    end else if (pop) begin
                        head_d       = EMPTY_VAL;
                        head_valid_d = 1'b0;
                    end
                end
                default: begin
                    if (pop) begin
                        head_d       = skid_q;
                        skid_valid_d = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q       <= EMPTY_VAL;
            skid_q       <= '0;
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            skid_q       <= skid_d;
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign in_ready  = !skid_valid_q;
    assign out_valid = head_valid_q;
    assign out_data  = head_q;
    assign occupancy = occ_count(head_valid_q, skid_valid_q);

endmodule

// File: rtl/if_id_stage_buf.sv
// IF/ID pipeline stage: carries {pc_in + PC_INC, inst_in} from fetch to decode
// through a 2-entry skid buffer, with flush on redirect and a saturating count
// of cycles in which decode refused a valid instruction.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   in_valid, in_ready          fetch handshake
//   pc_in, inst_in              fetched PC and instruction
//   flush                       branch/jump redirect
//   out_valid, out_ready        decode handshake
//   pc_out, inst_out            head entry; 0 / NOP_INST when empty
//   occupancy                   entries held
//   stall_cnt                   saturating decode-stall counter
module if_id_stage_buf
    import if_id_pkg::*;
#(
    parameter int                  INST_W      = INST_W_DEF,
    parameter int                  PC_W        = PC_W_DEF,
    parameter int                  PC_INC      = 1,
    parameter logic [INST_W-1:0]   NOP_INST    = INST_W'(NOP_INST_DEF),
    parameter int                  STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PC_W-1:0]        pc_in,
    input  logic [INST_W-1:0]      inst_in,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_W-1:0]        pc_out,
    output logic [INST_W-1:0]      inst_out,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int PAY_W = PC_W + INST_W;

    logic [PC_W-1:0]        pc_next;
    logic [PAY_W-1:0]       pay_in;
    logic [PAY_W-1:0]       pay_out;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Increment wraps modulo 2^PC_W by truncation.
    assign pc_next = pc_in + PC_W'(PC_INC);
    assign pay_in  = {pc_next, inst_in};

    // Empty head is loaded with {0, NOP} so the substitution is registered.
    pipe_skid_buf #(
        .W         (PAY_W),
        .EMPTY_VAL ({{PC_W{1'b0}}, NOP_INST})
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pay_in),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pay_out),
        .occupancy (occupancy)
    );

    assign pc_out   = pay_out[PAY_W-1:INST_W];
    assign inst_out = pay_out[INST_W-1:0];

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_if_id_stage_buf.sv
module tb_if_id_stage_buf;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // default-parameter instance
    logic        reset, in_valid, flush, out_ready;
    logic [31:0] pc_in, inst_in;
    logic        in_ready, out_valid;
    logic [31:0] pc_out, inst_out;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;

    // narrow instance: PC_W=8, PC_INC=4, STALL_CNT_W=3
    logic        b_reset, b_in_valid, b_flush, b_out_ready;
    logic [7:0]  b_pc_in;
    logic [31:0] b_inst_in;
    logic        b_in_ready, b_out_valid;
    logic [7:0]  b_pc_out;
    logic [31:0] b_inst_out;
    logic [1:0]  b_occupancy;
    logic [2:0]  b_stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    if_id_stage_buf u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .inst_in(inst_in), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .inst_out(inst_out),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    if_id_stage_buf #(.PC_W(8), .PC_INC(4), .STALL_CNT_W(3)) u_dut_b (
        .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .pc_in(b_pc_in), .inst_in(b_inst_in), .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .pc_out(b_pc_out), .inst_out(b_inst_out),
        .occupancy(b_occupancy), .stall_cnt(b_stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst);
        in_valid = 1'b1;
        pc_in    = pc;
        inst_in  = inst;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, ".occ"},   64'(occupancy), 64'd0);
        chk({tag, ".valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".pc"},    64'(pc_out),    64'd0);
        chk({tag, ".inst"},  64'(inst_out),  64'd0);
        chk({tag, ".rdy"},   64'(in_ready),  64'd1);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        pc_in = '0; inst_in = '0;
        b_reset = 1'b1; b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b0;
        b_pc_in = '0; b_inst_in = '0;
        tick();
        tick();
        reset = 1'b0; b_reset = 1'b0;
        chk_empty("rst");
        chk("rst.stall", 64'(stall_cnt), 64'd0);

        // streaming with decode always ready
        out_ready = 1'b1;
        push(32'd0, 32'hAAAA_0001); tick();
        chk("s0.pc", 64'(pc_out), 64'd1);   chk("s0.inst", 64'(inst_out), 64'hAAAA_0001);
        chk("s0.occ", 64'(occupancy), 64'd1); chk("s0.rdy", 64'(in_ready), 64'd1);
        push(32'd1, 32'hBBBB_0002); tick();
        chk("s1.pc", 64'(pc_out), 64'd2);   chk("s1.inst", 64'(inst_out), 64'hBBBB_0002);
        chk("s1.occ", 64'(occupancy), 64'd1); chk("s1.rdy", 64'(in_ready), 64'd1);
        push(32'd2, 32'hCCCC_0003); tick();
        chk("s2.pc", 64'(pc_out), 64'd3);   chk("s2.inst", 64'(inst_out), 64'hCCCC_0003);
        in_valid = 1'b0; tick();
        chk_empty("drain");

        // backpressure
        out_ready = 1'b0;
        push(32'd10, 32'hDDDD_0010); tick();
        chk("bp0.pc", 64'(pc_out), 64'd11); chk("bp0.occ", 64'(occupancy), 64'd1);
        chk("bp0.rdy", 64'(in_ready), 64'd1); chk("bp0.stall", 64'(stall_cnt), 64'd0);
        push(32'd11, 32'hEEEE_0011); tick();
        chk("bp1.pc", 64'(pc_out), 64'd11); chk("bp1.occ", 64'(occupancy), 64'd2);
        chk("bp1.rdy", 64'(in_ready), 64'd0); chk("bp1.stall", 64'(stall_cnt), 64'd1);
        push(32'd99, 32'h9999_9999); tick();   // refused: buffer full
        chk("bp2.pc", 64'(pc_out), 64'd11); chk("bp2.inst", 64'(inst_out), 64'hDDDD_0010);
        chk("bp2.occ", 64'(occupancy), 64'd2); chk("bp2.stall", 64'(stall_cnt), 64'd2);
        in_valid = 1'b0; out_ready = 1'b1; tick();
        chk("bp3.pc", 64'(pc_out), 64'd12); chk("bp3.inst", 64'(inst_out), 64'hEEEE_0011);
        chk("bp3.occ", 64'(occupancy), 64'd1); chk("bp3.rdy", 64'(in_ready), 64'd1);
        chk("bp3.stall", 64'(stall_cnt), 64'd2);
        tick();
        chk_empty("bp4");

        // flush with full buffer and same-cycle input
        out_ready = 1'b0;
        push(32'd30, 32'h3030_3030); tick();
        push(32'd31, 32'h3131_3131); tick();
        chk("fl0.occ", 64'(occupancy), 64'd2);
        chk("fl0.stall", 64'(stall_cnt), 64'd3);
        push(32'd20, 32'h2020_2020); flush = 1'b1; tick();
        chk_empty("fl1");
        chk("fl1.stall", 64'(stall_cnt), 64'd4);
        flush = 1'b0; in_valid = 1'b0; tick();
        chk_empty("fl2");
        chk("fl2.stall", 64'(stall_cnt), 64'd4);

        // reset while full and stalled
        push(32'd40, 32'h4040_4040); tick();
        push(32'd41, 32'h4141_4141); tick();
        chk("rf0.occ", 64'(occupancy), 64'd2);
        in_valid = 1'b0; reset = 1'b1; tick();
        reset = 1'b0;
        chk_empty("rf1");
        chk("rf1.stall", 64'(stall_cnt), 64'd0);

        // narrow instance: PC wrap and stall counter saturation
        b_out_ready = 1'b0;
        b_in_valid = 1'b1; b_pc_in = 8'hFE; b_inst_in = 32'h1234_5678; tick();
        b_in_valid = 1'b0;
        chk("wrap.pc", 64'(b_pc_out), 64'h02);
        chk("wrap.inst", 64'(b_inst_out), 64'h1234_5678);
        chk("wrap.stall", 64'(b_stall_cnt), 64'd0);
        for (int i = 0; i < 6; i++) tick();
        chk("sat6", 64'(b_stall_cnt), 64'd6);
        for (int i = 0; i < 4; i++) tick();
        chk("sat10", 64'(b_stall_cnt), 64'd7);
        chk("sat.pc", 64'(b_pc_out), 64'h02);
        chk("sat.valid", 64'(b_out_valid), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
